core_control_psr_bank: RTL and testbench

//  Banked program-status register file for the core control unit: holds CPSR plus one SPSR per

---
 rtl/core_control_psr_bank.sv | 249 ++++++++++++++++++++++++
 tb/tb_core_control_psr_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_control_psr_bank.sv
// core_control_psr_bank
// Banked program-status register file for the core control unit. Holds the
// CPSR plus one SPSR per privileged exception mode (fiq, irq, svc, abt, und).
// It arbitrates ALU flag writebacks, MSR byte-field writes and SPSR restores,
// and runs exception entry (save CPSR, switch mode, mask interrupts) through
// a three-state sequencer. The mode output drives register-file banking.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   i_flags_wr   load CPSR[31:28] from i_flags_in
//   i_flags_in   NZCV
//   i_msr_wr     MSR write request
//   i_msr_saved  1 = target the SPSR of the current mode, 0 = CPSR
//   i_msr_mask   byte-field mask {f,s,x,c}; bit i enables byte i
//   i_msr_data   MSR source value
//   i_restore    copy current-mode SPSR into CPSR (exception return)
//   i_exc_req    exception entry request, only sampled while idle
//   i_exc_mode   target mode of the exception
//   i_exc_mask_f also set F on entry
//   o_cpsr       current CPSR
//   o_spsr       SPSR of the current mode; equals CPSR when no bank exists
//   o_mode       CPSR[4:0]
//   o_busy       exception sequence in progress
//   o_exc_done   one-cycle pulse; the new mode is on o_cpsr the next cycle
//   o_bad_mode   one-cycle pulse after a rejected mode-field write
module core_control_psr_bank #(
  parameter int         N_SPSR     = 5,
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flags_wr,
  input  logic [3:0]  i_flags_in,
  input  logic        i_msr_wr,
  input  logic        i_msr_saved,
  input  logic [3:0]  i_msr_mask,
  input  logic [31:0] i_msr_data,
  input  logic        i_restore,
  input  logic        i_exc_req,
  input  logic [4:0]  i_exc_mode,
  input  logic        i_exc_mask_f,
  output logic [31:0] o_cpsr,
  output logic [31:0] o_spsr,
  output logic [4:0]  o_mode,
  output logic        o_busy,
  output logic        o_exc_done,
  output logic        o_bad_mode
);

  localparam logic [4:0]  MODE_USR  = 5'b10000;
  localparam logic [31:0] CPSR_INIT = {24'b0, 3'b110, RESET_MODE};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SWITCH
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_cpsr;
  logic [31:0] r_spsr [0:4];
  logic [4:0]  r_excMode;
  logic        r_excMaskF;
  logic        r_badMode;

  logic [31:0] w_cpsrNext;
  logic        w_spsrWe;
  logic [2:0]  w_spsrIdx;
  logic [31:0] w_spsrData;
  logic        w_badModeNext;
  logic [3:0]  w_msrMask;
  logic [2:0]  w_curIdx;
  logic        w_curHasBank;
  logic        w_excHasBank;
  logic [31:0] w_curSpsr;

  // Only the seven architectural mode encodings are legal in the mode field.
  function automatic logic modeValid(input logic [4:0] m);
    case (m)
      5'b10000, 5'b10001, 5'b10010, 5'b10011,
      5'b10111, 5'b11011, 5'b11111: modeValid = 1'b1;
      default:                      modeValid = 1'b0;
    endcase
  endfunction

  // Bank slot for each privileged exception mode; 7 marks "no bank".
  function automatic logic [2:0] bankIndex(input logic [4:0] m);
    case (m)
      5'b10001: bankIndex = 3'd0;
      5'b10010: bankIndex = 3'd1;
      5'b10011: bankIndex = 3'd2;
      5'b10111: bankIndex = 3'd3;
      5'b11011: bankIndex = 3'd4;
      default:  bankIndex = 3'd7;
    endcase
  endfunction

  // A mode owns an SPSR only if its slot is among the N_SPSR implemented
  // banks; usr, sys, invalid encodings and trimmed banks all behave alike.
  function automatic logic hasBank(input logic [4:0] m);
    hasBank = (int'(bankIndex(m)) < N_SPSR);
  endfunction

  assign w_curIdx     = bankIndex(r_cpsr[4:0]);
  assign w_curHasBank = hasBank(r_cpsr[4:0]);
  assign w_excHasBank = hasBank(r_excMode);

  // Current-mode SPSR view; without a bank the CPSR is mirrored so that
  // callers reading o_spsr in usr/sys see a harmless value.
  always_comb begin
    w_curSpsr = r_cpsr;
    if (w_curHasBank) begin
      w_curSpsr = r_spsr[w_curIdx];
    end
  end

  // Sequencer: an accepted exception spends one cycle saving the CPSR and
  // one cycle switching mode; busy covers both so requests are ignored.
  always_comb begin
    w_stateNext = r_state;
    o_busy      = 1'b0;
    o_exc_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_exc_req) begin
          w_stateNext = ST_SAVE;
        end
      end
      ST_SAVE: begin
        o_busy      = 1'b1;
        w_stateNext = ST_SWITCH;
      end
      ST_SWITCH: begin
        o_busy      = 1'b1;
        o_exc_done  = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Next-value selection for CPSR and the single SPSR write port. In idle
  // the request priority is exception > restore > MSR > flags; a flags
  // writeback survives alongside an MSR that leaves byte 3 alone.
  always_comb begin
    w_cpsrNext    = r_cpsr;
    w_spsrWe      = 1'b0;
    w_spsrIdx     = w_curIdx;
    w_spsrData    = w_curSpsr;
    w_badModeNext = 1'b0;
    w_msrMask     = i_msr_mask;
    unique case (r_state)
      ST_IDLE: begin
        if (!i_exc_req) begin
          if (i_restore) begin
            if (w_curHasBank) begin
              w_cpsrNext = w_curSpsr;
              if (!modeValid(w_curSpsr[4:0])) begin
                w_cpsrNext[4:0] = r_cpsr[4:0];
                w_badModeNext   = 1'b1;
              end
            end
          end else begin
            if (i_msr_wr && !i_msr_saved) begin
              // User code may only touch the flags byte; a privileged write
              // carrying an illegal mode drops just the control byte.
              if (r_cpsr[4:0] == MODE_USR) begin
                w_msrMask = i_msr_mask & 4'b1000;
              end else if (i_msr_mask[0] && !modeValid(i_msr_data[4:0])) begin
                w_msrMask[0]  = 1'b0;
                w_badModeNext = 1'b1;
              end
              for (int i = 0; i < 4; i++) begin
                if (w_msrMask[i]) begin
                  w_cpsrNext[8*i +: 8] = i_msr_data[8*i +: 8];
                end
              end
            end
            if (i_msr_wr && i_msr_saved && w_curHasBank) begin
              w_spsrWe = 1'b1;
              for (int i = 0; i < 4; i++) begin
                if (i_msr_mask[i]) begin
                  w_spsrData[8*i +: 8] = i_msr_data[8*i +: 8];
                end
              end
            end
            if (i_flags_wr && !(i_msr_wr && i_msr_mask[3])) begin
              w_cpsrNext[31:28] = i_flags_in;
            end
          end
        end
      end
      ST_SAVE: begin
        if (w_excHasBank) begin
          w_spsrWe   = 1'b1;
          w_spsrIdx  = bankIndex(r_excMode);
          w_spsrData = r_cpsr;
        end else begin
          w_badModeNext = 1'b1;
        end
      end
      ST_SWITCH: begin
        w_cpsrNext[4:0] = r_excMode;
        w_cpsrNext[7]   = 1'b1;
        if (r_excMaskF) begin
          w_cpsrNext[6] = 1'b1;
        end
        w_cpsrNext[5] = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // State and storage registers; reset also wipes any half-finished save.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cpsr     <= CPSR_INIT;
      r_excMode  <= RESET_MODE;
      r_excMaskF <= 1'b0;
      r_badMode  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_spsr[i] <= '0;
      end
    end else begin
      r_state   <= w_stateNext;
      r_cpsr    <= w_cpsrNext;
      r_badMode <= w_badModeNext;
      if (w_spsrWe) begin
        r_spsr[w_spsrIdx] <= w_spsrData;
      end
      if (r_state == ST_IDLE && i_exc_req) begin
        r_excMode  <= i_exc_mode;
        r_excMaskF <= i_exc_mask_f;
      end
    end
  end

  assign o_cpsr     = r_cpsr;
  assign o_spsr     = w_curSpsr;
  assign o_mode     = r_cpsr[4:0];
  assign o_bad_mode = r_badMode;

endmodule

// File: tb/tb_core_control_psr_bank.sv
// tb_core_control_psr_bank
// Directed scenarios with hand-derived expectations, followed by a random
// run compared cycle by cycle against a behavioural model of the PSR bank.
module tb_core_control_psr_bank;

  logic        clk;
  logic        rst;
  logic        flagsWr;
  logic [3:0]  flagsIn;
  logic        msrWr;
  logic        msrSaved;
  logic [3:0]  msrMask;
  logic [31:0] msrData;
  logic        restore;
  logic        excReq;
  logic [4:0]  excMode;
  logic        excMaskF;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic [4:0]  mode;
  logic        busy;
  logic        excDone;
  logic        badMode;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model state
  logic [31:0] mCpsr;
  logic [31:0] mSpsr [5];
  int          mBusyLeft;
  logic [4:0]  mExcMode;
  logic        mExcF;
  logic        mBad;

  core_control_psr_bank dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flags_wr  (flagsWr),
    .i_flags_in  (flagsIn),
    .i_msr_wr    (msrWr),
    .i_msr_saved (msrSaved),
    .i_msr_mask  (msrMask),
    .i_msr_data  (msrData),
    .i_restore   (restore),
    .i_exc_req   (excReq),
    .i_exc_mode  (excMode),
    .i_exc_mask_f(excMaskF),
    .o_cpsr      (cpsr),
    .o_spsr      (spsr),
    .o_mode      (mode),
    .o_busy      (busy),
    .o_exc_done  (excDone),
    .o_bad_mode  (badMode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bankOf(input logic [4:0] m);
    case (m)
      5'h11:   return 0;
      5'h12:   return 1;
      5'h13:   return 2;
      5'h17:   return 3;
      5'h1B:   return 4;
      default: return -1;
    endcase
  endfunction

  function automatic bit isValid(input logic [4:0] m);
    return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
  endfunction

  function automatic logic [31:0] modelSpsr();
    int b = bankOf(mCpsr[4:0]);
    return (b >= 0) ? mSpsr[b] : mCpsr;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    logic [31:0] nc;
    bit          bad;
    int          b;
    nc  = mCpsr;
    bad = 0;
    if (rst) begin
      mCpsr     = 32'h000000D3;
      for (int i = 0; i < 5; i++) mSpsr[i] = '0;
      mBusyLeft = 0;
      mBad      = 1'b0;
      return;
    end
    if (mBusyLeft == 2) begin
      b = bankOf(mExcMode);
      if (b >= 0) mSpsr[b] = mCpsr;
      else bad = 1;
      mBusyLeft = 1;
    end else if (mBusyLeft == 1) begin
      nc[4:0] = mExcMode;
      nc[7]   = 1'b1;
      if (mExcF) nc[6] = 1'b1;
      nc[5]   = 1'b0;
      mBusyLeft = 0;
    end else if (excReq) begin
      mExcMode  = excMode;
      mExcF     = excMaskF;
      mBusyLeft = 2;
    end else if (restore) begin
      b = bankOf(mCpsr[4:0]);
      if (b >= 0) begin
        nc = mSpsr[b];
        if (!isValid(nc[4:0])) begin
          nc[4:0] = mCpsr[4:0];
          bad = 1;
        end
      end
    end else begin
      if (msrWr && !msrSaved) begin
        for (int i = 0; i < 4; i++) begin
          if (msrMask[i] && (mCpsr[4:0] != 5'h10 || i == 3)) begin
            if (i == 0 && !isValid(msrData[4:0])) bad = 1;
            else nc[8*i +: 8] = msrData[8*i +: 8];
          end
        end
      end
      if (msrWr && msrSaved) begin
        b = bankOf(mCpsr[4:0]);
        if (b >= 0) begin
          for (int i = 0; i < 4; i++) begin
            if (msrMask[i]) mSpsr[b][8*i +: 8] = msrData[8*i +: 8];
          end
        end
      end
      if (flagsWr && !(msrWr && msrMask[3])) nc[31:28] = flagsIn;
    end
    mCpsr = nc;
    mBad  = bad;
  endtask

  task automatic clearInputs();
    rst = 0; flagsWr = 0; flagsIn = 0; msrWr = 0; msrSaved = 0; msrMask = 0;
    msrData = 0; restore = 0; excReq = 0; excMode = 0; excMaskF = 0;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1;
    tick();
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL reset_cpsr got %h want %h", cpsr, 32'hD3); else passCount++;
    checkCount++; if (spsr !== 32'h0) $display("[TB] FAIL reset_spsr got %h want %h", spsr, 32'h0); else passCount++;
    checkCount++; if ({busy, excDone, badMode} !== 3'b000) $display("[TB] FAIL reset_flags got %b want 000", {busy, excDone, badMode}); else passCount++;
    rst = 0;
    tick();
    tick();
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL idle_hold_cpsr got %h want %h", cpsr, 32'hD3); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL idle_hold_busy got %b want 0", busy); else passCount++;
  endtask

  task automatic test_exception();
    int pulses = 0;
    excReq = 1; excMode = 5'h12; excMaskF = 0;
    tick();
    clearInputs();
    checkCount++; if ({busy, excDone} !== 2'b10) $display("[TB] FAIL exc_save_phase got %b want 10", {busy, excDone}); else passCount++;
    pulses += excDone;
    tick();
    pulses += excDone;
    checkCount++; if ({busy, excDone} !== 2'b11) $display("[TB] FAIL exc_switch_phase got %b want 11", {busy, excDone}); else passCount++;
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL exc_not_yet got %h want %h", cpsr, 32'hD3); else passCount++;
    tick();
    pulses += excDone;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL exc_busy_clear got %b want 0", busy); else passCount++;
    // I set, F kept from the svc value, T cleared, mode irq
    checkCount++; if (cpsr !== 32'hD2) $display("[TB] FAIL exc_cpsr got %h want %h", cpsr, 32'hD2); else passCount++;
    checkCount++; if (mode !== 5'h12) $display("[TB] FAIL exc_mode got %h want %h", mode, 5'h12); else passCount++;
    checkCount++; if (spsr !== 32'hD3) $display("[TB] FAIL exc_spsr_irq got %h want %h", spsr, 32'hD3); else passCount++;
    checkCount++; if (pulses !== 1) $display("[TB] FAIL exc_done_count got %0d want 1", pulses); else passCount++;
  endtask

  task automatic test_restore();
    restore = 1; flagsWr = 1; flagsIn = 4'hF;
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL restore_cpsr got %h want %h", cpsr, 32'hD3); else passCount++;
    checkCount++; if (cpsr[31:28] !== 4'h0) $display("[TB] FAIL restore_flags_dropped got %h want 0", cpsr[31:28]); else passCount++;
  endtask

  task automatic test_exception_f_clear();
    msrWr = 1; msrMask = 4'b0001; msrData = 32'h13;
    tick();
    clearInputs();
    excReq = 1; excMode = 5'h12;
    tick();
    clearInputs();
    tick();
    tick();
    checkCount++; if (cpsr !== 32'h92) $display("[TB] FAIL excf_cpsr got %h want %h", cpsr, 32'h92); else passCount++;
    checkCount++; if (spsr !== 32'h13) $display("[TB] FAIL excf_spsr got %h want %h", spsr, 32'h13); else passCount++;
    restore = 1;
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'h13) $display("[TB] FAIL excf_return got %h want %h", cpsr, 32'h13); else passCount++;
  endtask

  task automatic test_usr_msr();
    msrWr = 1; msrMask = 4'b0001; msrData = 32'h10;
    tick();
    msrMask = 4'hF; msrData = 32'hF00000D3;
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'hF0000010) $display("[TB] FAIL usr_msr_cpsr got %h want %h", cpsr, 32'hF0000010); else passCount++;
    checkCount++; if (badMode !== 1'b0) $display("[TB] FAIL usr_msr_bad got %b want 0", badMode); else passCount++;
    msrWr = 1; msrSaved = 1; msrMask = 4'hF; msrData = 32'h12345678;
    tick();
    clearInputs();
    checkCount++; if (spsr !== 32'hF0000010) $display("[TB] FAIL usr_spsr_mirror got %h want %h", spsr, 32'hF0000010); else passCount++;
    excReq = 1; excMode = 5'h13; excMaskF = 1;
    tick();
    clearInputs();
    tick();
    tick();
    checkCount++; if (cpsr !== 32'hF00000D3) $display("[TB] FAIL usr_to_svc got %h want %h", cpsr, 32'hF00000D3); else passCount++;
    checkCount++; if (spsr !== 32'hF0000010) $display("[TB] FAIL usr_to_svc_spsr got %h want %h", spsr, 32'hF0000010); else passCount++;
  endtask

  task automatic test_bad_msr();
    msrWr = 1; msrMask = 4'b0001; msrData = 32'h1E;
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'hF00000D3) $display("[TB] FAIL bad_msr_cpsr got %h want %h", cpsr, 32'hF00000D3); else passCount++;
    checkCount++; if (badMode !== 1'b1) $display("[TB] FAIL bad_msr_pulse got %b want 1", badMode); else passCount++;
    tick();
    checkCount++; if (badMode !== 1'b0) $display("[TB] FAIL bad_msr_pulse_end got %b want 0", badMode); else passCount++;
  endtask

  task automatic test_merge();
    msrWr = 1; msrMask = 4'b0010; msrData = 32'h0000AB00; flagsWr = 1; flagsIn = 4'h5;
    tick();
    checkCount++; if (cpsr !== 32'h5000ABD3) $display("[TB] FAIL merge_both got %h want %h", cpsr, 32'h5000ABD3); else passCount++;
    msrMask = 4'b1000; msrData = 32'h30000000; flagsIn = 4'hC;
    tick();
    checkCount++; if (cpsr !== 32'h3000ABD3) $display("[TB] FAIL merge_flags_dropped got %h want %h", cpsr, 32'h3000ABD3); else passCount++;
    clearInputs();
    msrWr = 1; msrSaved = 1; msrMask = 4'hF; msrData = 32'h12345611;
    tick();
    clearInputs();
    checkCount++; if (spsr !== 32'h12345611) $display("[TB] FAIL msr_spsr got %h want %h", spsr, 32'h12345611); else passCount++;
    restore = 1;
    tick();
    checkCount++; if (cpsr !== 32'h12345611) $display("[TB] FAIL restore_to_fiq got %h want %h", cpsr, 32'h12345611); else passCount++;
    // the fiq bank still holds zero, an illegal mode field
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'h00000011) $display("[TB] FAIL restore_bad_cpsr got %h want %h", cpsr, 32'h11); else passCount++;
    checkCount++; if (badMode !== 1'b1) $display("[TB] FAIL restore_bad_pulse got %b want 1", badMode); else passCount++;
    msrWr = 1; msrMask = 4'b0001; msrData = 32'hD3;
    tick();
    clearInputs();
  endtask

  task automatic test_invalid_exc();
    excReq = 1; excMode = 5'h00;
    tick();
    clearInputs();
    tick();
    checkCount++; if ({excDone, badMode} !== 2'b11) $display("[TB] FAIL inv_exc_pulses got %b want 11", {excDone, badMode}); else passCount++;
    tick();
    checkCount++; if (cpsr !== 32'hC0) $display("[TB] FAIL inv_exc_cpsr got %h want %h", cpsr, 32'hC0); else passCount++;
    checkCount++; if (spsr !== 32'hC0) $display("[TB] FAIL inv_exc_spsr got %h want %h", spsr, 32'hC0); else passCount++;
    msrWr = 1; msrMask = 4'b0001; msrData = 32'hD3;
    tick();
    clearInputs();
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL inv_exc_recover got %h want %h", cpsr, 32'hD3); else passCount++;
  endtask

  task automatic test_back_to_back();
    excReq = 1; excMode = 5'h17; excMaskF = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkCount++; if (cpsr !== mCpsr || busy !== (mBusyLeft != 0)) $display("[TB] FAIL b2b_cycle%0d got %h/%b want %h/%b", c, cpsr, busy, mCpsr, mBusyLeft != 0); else passCount++;
    end
    clearInputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    excReq = 1; excMode = 5'h11;
    tick();
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
    checkCount++; if (cpsr !== 32'hD3) $display("[TB] FAIL mid_rst_cpsr got %h want %h", cpsr, 32'hD3); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL mid_rst_busy got %b want 0", busy); else passCount++;
    checkCount++; if (spsr !== 32'h0) $display("[TB] FAIL mid_rst_spsr got %h want 0", spsr); else passCount++;
    tick();
    checkCount++; if ({busy, excDone} !== 2'b00) $display("[TB] FAIL mid_rst_idle got %b want 00", {busy, excDone}); else passCount++;
  endtask

  task automatic test_random();
    logic [4:0] modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      excReq   = ($urandom_range(0, 9) == 0);
      excMode  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : modes[$urandom_range(0, 6)];
      excMaskF = 1'($urandom);
      restore  = ($urandom_range(0, 7) == 0);
      msrWr    = ($urandom_range(0, 2) == 0);
      msrSaved = 1'($urandom);
      msrMask  = 4'($urandom);
      msrData  = $urandom;
      if ($urandom_range(0, 3) != 0) msrData[4:0] = modes[$urandom_range(0, 6)];
      flagsWr  = 1'($urandom);
      flagsIn  = 4'($urandom);
      tick();
      checkCount++; if (cpsr !== mCpsr) $display("[TB] FAIL rnd_cpsr c%0d got %h want %h", c, cpsr, mCpsr); else passCount++;
      checkCount++; if (spsr !== modelSpsr()) $display("[TB] FAIL rnd_spsr c%0d got %h want %h", c, spsr, modelSpsr()); else passCount++;
      checkCount++; if (mode !== mCpsr[4:0]) $display("[TB] FAIL rnd_mode c%0d got %h want %h", c, mode, mCpsr[4:0]); else passCount++;
      checkCount++; if (busy !== (mBusyLeft != 0)) $display("[TB] FAIL rnd_busy c%0d got %b want %b", c, busy, mBusyLeft != 0); else passCount++;
      checkCount++; if (excDone !== (mBusyLeft == 1)) $display("[TB] FAIL rnd_exc_done c%0d got %b want %b", c, excDone, mBusyLeft == 1); else passCount++;
      checkCount++; if (badMode !== mBad) $display("[TB] FAIL rnd_bad_mode c%0d got %b want %b", c, badMode, mBad); else passCount++;
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    mCpsr = 0; mBusyLeft = 0; mExcMode = 0; mExcF = 0; mBad = 0;
    for (int i = 0; i < 5; i++) mSpsr[i] = '0;
    test_reset();
    test_exception();
    test_restore();
    test_exception_f_clear();
    test_usr_msr();
    test_bad_msr();
    test_merge();
    test_invalid_exc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
